// File: rtl/ysyx_25030093_trap_pkg.sv
// Shared definitions for the machine-mode trap unit: CSR addresses, cause codes,
// trap_kind encoding and FSM state encoding.
package ysyx_25030093_trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [4:0] CAUSE_ILLEGAL_INSTR = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT    = 5'd3;
  localparam logic [4:0] CAUSE_ECALL_M       = 5'd11;

  // Bit positions inside mstatus.
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;

  typedef enum logic [1:0] {
    KIND_ECALL   = 2'b00,
    KIND_EBREAK  = 2'b01,
    KIND_MRET    = 2'b10,
    KIND_ILLEGAL = 2'b11
  } trap_kind_t;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_W_EPC    = 3'd1;
  localparam state_t ST_W_CAUSE  = 3'd2;
  localparam state_t ST_W_STATUS = 3'd3;
  localparam state_t ST_REDIRECT = 3'd4;

endpackage

// File: rtl/ysyx_25030093_trap_cause_enc.sv
// Combinational mapping from trap kind to the mcause value written by the trap unit.
module ysyx_25030093_trap_cause_enc
  import ysyx_25030093_trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  trap_kind_t        kind,
  output logic [XLEN-1:0]   cause
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves cause unassigned (no latch).
    cause = '0;
    case (kind)
      KIND_ECALL:   cause = XLEN'(CAUSE_ECALL_M);
      KIND_EBREAK:  cause = XLEN'(CAUSE_BREAKPOINT);
      KIND_ILLEGAL: cause = XLEN'(CAUSE_ILLEGAL_INSTR);
      default:      cause = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_25030093_trap_unit.sv
// Machine-mode trap/return sequencer: writes mepc/mcause (and mstatus when
// YSYX_25030093_TRAP_MSTATUS_EN is defined), then redirects fetch.
module ysyx_25030093_trap_unit
  import ysyx_25030093_trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  output logic            trap_ready,
  input  logic [1:0]      trap_kind,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] mtvec_rdata,
  input  logic [XLEN-1:0] mepc_rdata,
  input  logic [XLEN-1:0] mstatus_rdata,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            busy
);

  state_t          state, state_nxt;
  trap_kind_t      kind_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] cause;
  logic            accept;
  logic            is_mret;

  assign is_mret    = (trap_kind == KIND_MRET);
  assign trap_ready = (state == ST_IDLE) && !rst;
  assign accept     = trap_valid && trap_ready;
  assign busy       = (state != ST_IDLE);

  ysyx_25030093_trap_cause_enc #(.XLEN(XLEN)) u_cause_enc (
    .kind  (kind_q),
    .cause (cause)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef YSYX_25030093_TRAP_MSTATUS_EN
          state_nxt = is_mret ? ST_W_STATUS : ST_W_EPC;
`else
          state_nxt = is_mret ? ST_REDIRECT : ST_W_EPC;
`endif
        end
      end
      ST_W_EPC: state_nxt = ST_W_CAUSE;
`ifdef YSYX_25030093_TRAP_MSTATUS_EN
      ST_W_CAUSE:  state_nxt = ST_W_STATUS;
      ST_W_STATUS: state_nxt = ST_REDIRECT;
`else
      ST_W_CAUSE:  state_nxt = ST_REDIRECT;
`endif
      ST_REDIRECT: if (redirect_ready) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      kind_q   <= KIND_ECALL;
      pc_q     <= '0;
      target_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state <= state_nxt;
      if (accept) begin
        kind_q   <= trap_kind_t'(trap_kind);
        pc_q     <= trap_pc;
        target_q <= is_mret ? mepc_rdata : {mtvec_rdata[XLEN-1:2], 2'b00};
      end
    end
  end

`ifdef YSYX_25030093_TRAP_MSTATUS_EN
  logic [XLEN-1:0] status_nxt;
  logic [XLEN-1:0] status_q;

  // mstatus image is computed from the value seen at acceptance, not at write time.
  always_comb begin
    status_nxt                      = mstatus_rdata;
    status_nxt[MSTATUS_MPP +: 2]    = 2'b11;
    if (is_mret) begin
      status_nxt[MSTATUS_MIE]  = mstatus_rdata[MSTATUS_MPIE];
      status_nxt[MSTATUS_MPIE] = 1'b1;
    end else begin
      status_nxt[MSTATUS_MPIE] = mstatus_rdata[MSTATUS_MIE];
      status_nxt[MSTATUS_MIE]  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         status_q <= '0;
    else if (accept) status_q <= status_nxt;
  end
`else
  logic unused_mstatus;
  assign unused_mstatus = ^mstatus_rdata;
`endif

  always_comb begin
    csr_wen   = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    case (state)
      ST_W_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = pc_q;
      end
      ST_W_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause;
      end
`ifdef YSYX_25030093_TRAP_MSTATUS_EN
      ST_W_STATUS: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = status_q;
      end
`endif
      default: ;
    endcase
  end

  assign redirect_valid = (state == ST_REDIRECT);
  assign redirect_pc    = redirect_valid ? target_q : '0;

endmodule

// File: tb/tb_ysyx_25030093_trap_unit.sv
// Directed self-checking bench for ysyx_25030093_trap_unit; follows
// YSYX_25030093_TRAP_MSTATUS_EN when it is defined for the build.
module tb_ysyx_25030093_trap_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            trap_valid;
  logic            trap_ready;
  logic [1:0]      trap_kind;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] mtvec_rdata;
  logic [XLEN-1:0] mepc_rdata;
  logic [XLEN-1:0] mstatus_rdata;
  logic            csr_wen;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            busy;

  int checks = 0;
  int errors = 0;

  ysyx_25030093_trap_unit #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .trap_valid     (trap_valid),
    .trap_ready     (trap_ready),
    .trap_kind      (trap_kind),
    .trap_pc        (trap_pc),
    .mtvec_rdata    (mtvec_rdata),
    .mepc_rdata     (mepc_rdata),
    .mstatus_rdata  (mstatus_rdata),
    .csr_wen        (csr_wen),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_csr(input string tag, input logic wen, input logic [11:0] addr,
                            input logic [XLEN-1:0] data);
    check({tag, "_wen"}, csr_wen, wen);
    check({tag, "_waddr"}, csr_waddr, addr);
    check({tag, "_wdata"}, csr_wdata, data);
  endtask

  task automatic expect_redirect(input string tag, input logic valid, input logic [XLEN-1:0] pc);
    check({tag, "_rvalid"}, redirect_valid, valid);
    check({tag, "_rpc"}, redirect_pc, pc);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 12 && busy; i++) step();
    check({tag, "_idle_timeout"}, busy, 1'b0);
  endtask

  // Output invariants sampled on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (!csr_wen) begin
        check("inv_waddr_zero", csr_waddr, 12'h0);
        check("inv_wdata_zero", csr_wdata, '0);
      end
      if (!redirect_valid) check("inv_rpc_zero", redirect_pc, '0);
      check("inv_ready_not_busy", trap_ready, !busy);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; trap_valid = 1'b0; trap_kind = 2'b00; trap_pc = '0;
    mtvec_rdata = '0; mepc_rdata = '0; mstatus_rdata = '0; redirect_ready = 1'b0;

    // Reset state.
    #2;
    check("rst_trap_ready", trap_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    expect_csr("rst", 1'b0, 12'h0, '0);
    expect_redirect("rst", 1'b0, '0);
    step(); step();
    rst = 1'b0;
    step();
    check("post_rst_trap_ready", trap_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // ecall: mepc, mcause, [mstatus], redirect to mtvec with low bits cleared.
    trap_valid = 1'b1; trap_kind = 2'b00; trap_pc = 32'h8000_0010;
    mtvec_rdata = 32'h8000_0101; mepc_rdata = 32'h0000_dead;
    mstatus_rdata = 32'h0000_0008; redirect_ready = 1'b1;
    step();
    trap_valid = 1'b0; mtvec_rdata = 32'hffff_ffff; mstatus_rdata = '0;
    check("ecall_busy", busy, 1'b1);
    check("ecall_trap_ready", trap_ready, 1'b0);
    expect_csr("ecall_c1", 1'b1, 12'h341, 32'h8000_0010);
    expect_redirect("ecall_c1", 1'b0, '0);
    step();
    expect_csr("ecall_c2", 1'b1, 12'h342, 32'd11);
`ifdef YSYX_25030093_TRAP_MSTATUS_EN
    step();
    expect_csr("ecall_c3_status", 1'b1, 12'h300, 32'h0000_1880);
    expect_redirect("ecall_c3", 1'b0, '0);
`endif
    step();
    expect_redirect("ecall_redir", 1'b1, 32'h8000_0100);
    expect_csr("ecall_redir", 1'b0, 12'h0, '0);
    step();
    check("ecall_done_busy", busy, 1'b0);
    expect_redirect("ecall_done", 1'b0, '0);

    // mret: no mepc/mcause write, redirect to mepc.
    trap_valid = 1'b1; trap_kind = 2'b10; mepc_rdata = 32'h8000_0014;
    mstatus_rdata = 32'h0000_0080; redirect_ready = 1'b1;
    step();
    trap_valid = 1'b0; mepc_rdata = '0; mstatus_rdata = '0;
`ifdef YSYX_25030093_TRAP_MSTATUS_EN
    expect_csr("mret_status", 1'b1, 12'h300, 32'h0000_1888);
    step();
`endif
    expect_csr("mret_nowrite", 1'b0, 12'h0, '0);
    expect_redirect("mret_redir", 1'b1, 32'h8000_0014);
    step();
    check("mret_done_busy", busy, 1'b0);

    // ebreak with a stalled redirect and a competing request.
    trap_valid = 1'b1; trap_kind = 2'b01; trap_pc = 32'h0000_0100;
    mtvec_rdata = 32'h0000_2003; redirect_ready = 1'b0;
    step();
    trap_kind = 2'b11; trap_pc = 32'h0000_0200;
    expect_csr("ebreak_epc", 1'b1, 12'h341, 32'h0000_0100);
    step();
    expect_csr("ebreak_cause", 1'b1, 12'h342, 32'd3);
`ifdef YSYX_25030093_TRAP_MSTATUS_EN
    step();
`endif
    step();
    for (int i = 0; i < 5; i++) begin
      expect_redirect("stall", 1'b1, 32'h0000_2000);
      check("stall_trap_ready", trap_ready, 1'b0);
      step();
    end
    redirect_ready = 1'b1;
    step();
    check("handshake_busy", busy, 1'b0);
    check("handshake_trap_ready", trap_ready, 1'b1);
    expect_redirect("handshake", 1'b0, '0);
    step();
    trap_valid = 1'b0;
    expect_csr("illegal_epc", 1'b1, 12'h341, 32'h0000_0200);
    step();
    expect_csr("illegal_cause", 1'b1, 12'h342, 32'd2);
    wait_idle("illegal");

    // Reset while in W_CAUSE abandons the sequence.
    step();
    trap_valid = 1'b1; trap_kind = 2'b00; trap_pc = 32'h8000_0020;
    mtvec_rdata = 32'h8000_0200; redirect_ready = 1'b1;
    step();
    trap_valid = 1'b0;
    expect_csr("midrst_epc", 1'b1, 12'h341, 32'h8000_0020);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    expect_csr("midrst", 1'b0, 12'h0, '0);
    expect_redirect("midrst", 1'b0, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_trap_ready", trap_ready, 1'b0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("after_rst_busy", busy, 1'b0);
      check("after_rst_wen", csr_wen, 1'b0);
      check("after_rst_rvalid", redirect_valid, 1'b0);
    end
    check("after_rst_trap_ready", trap_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_trap_unit.md
YSYX_25030093_TRAP_UNIT -- requirements
Module: ysyx_25030093_trap_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: data/PC width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port trap_valid  input  1  core requests trap/return.
REQ-005 SHALL have port trap_ready  output  1  unit accepts request.
REQ-006 SHALL have port trap_kind  input  2  00 ecall, 01 ebreak, 10 mret, 11 illegal instruction.
REQ-007 SHALL have port trap_pc  input  XLEN  PC of the trapping instruction.
REQ-008 SHALL have port mtvec_rdata  input  XLEN  current mtvec from the CSR file.
REQ-009 SHALL have port mepc_rdata  input  XLEN  current mepc from the CSR file.
REQ-010 SHALL have port mstatus_rdata  input  XLEN  current mstatus from the CSR file.
REQ-011 SHALL have port csr_wen  output  1  CSR write strobe, one write per asserted cycle.
REQ-012 SHALL have port csr_waddr  output  12  CSR write address.
REQ-013 SHALL have port csr_wdata  output  XLEN  CSR write data.
REQ-014 SHALL have port redirect_valid  output  1  new PC available.
REQ-015 SHALL have port redirect_pc  output  XLEN  target PC.
REQ-016 SHALL have port redirect_ready  input  1  fetch accepts the redirect.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, W_EPC, W_CAUSE, W_STATUS, REDIRECT.
REQ-019 SHALL drive trap_ready=1 only in IDLE; a request is accepted on the edge where trap_valid & trap_ready.
REQ-020 SHALL, on acceptance, latch trap_kind and trap_pc, and latch target = mtvec_rdata & ~3 (trap kinds) or mepc_rdata (mret).
REQ-021 SHALL sequence trap kinds as IDLE -> W_EPC -> W_CAUSE -> [W_STATUS] -> REDIRECT, one cycle per W_* state.
REQ-022 SHALL sequence mret as IDLE -> [W_STATUS] -> REDIRECT, with no mepc or mcause write.
REQ-023 SHALL, in W_EPC, assert csr_wen with address 0x341 and the latched PC.
REQ-024 SHALL, in W_CAUSE, assert csr_wen with address 0x342 and cause 11 (ecall), 3 (ebreak) or 2 (illegal).
REQ-025 SHALL hold csr_wen=0 in IDLE and REDIRECT; csr_waddr/csr_wdata SHALL be 0 whenever csr_wen=0.
REQ-026 SHALL hold redirect_valid=1 and redirect_pc stable in REDIRECT until redirect_ready=1, then return to IDLE on that edge.
REQ-027 SHALL ignore trap_valid while busy; a new request is accepted no earlier than the cycle after the redirect handshake.
REQ-028 SHALL drive redirect_valid=0 and redirect_pc=0 outside REDIRECT.

Reset
REQ-029 SHALL, on rst assertion at any time, asynchronously enter IDLE with all latched values 0.
REQ-030 SHALL, at reset, drive trap_ready=0 while rst=1 and all other outputs 0.
REQ-031 SHALL abandon any trap in progress on reset mid-sequence without completing its remaining CSR writes or redirect.

Configuration
REQ-032 SHALL honour macro YSYX_25030093_TRAP_MSTATUS_EN.
REQ-033 SHALL, when the macro is defined, visit W_STATUS and write 0x300:
- trap: MPIE<-MIE, MIE<-0, MPP<-2'b11.
- mret: MIE<-MPIE, MPIE<-1, MPP<-2'b11.
- All other bits taken from mstatus_rdata sampled at acceptance.
REQ-034 SHALL, when the macro is undefined, skip W_STATUS entirely: trap latency is 3 cycles to redirect_valid; mret latency is 1 cycle.

Structure
REQ-035 SHALL take from shared package ysyx_25030093_trap_pkg:
- CSR addresses 0x300, 0x341, 0x342, 0x305.
- Cause codes.
- trap_kind encoding.
- FSM state enum.
REQ-036 SHALL place the kind-to-cause mapping in sub-module ysyx_25030093_trap_cause_enc (combinational); all other logic resides in the top module.

Verification
REQ-037 SHALL cover: ecall, trap_pc=0x80000010, mtvec=0x80000101, macro off -> cycle 1 write 0x341/0x80000010, cycle 2 write 0x342/11, cycle 3 redirect_pc=0x80000100.
REQ-038 SHALL cover: mret, mepc=0x80000014, macro off -> no CSR write, redirect_valid next cycle with redirect_pc=0x80000014.
REQ-039 SHALL cover: redirect_ready held 0 for 5 cycles -> redirect_valid and redirect_pc stable; trap_valid asserted meanwhile is not accepted (trap_ready=0).
REQ-040 SHALL cover: rst pulsed during W_CAUSE -> all outputs 0 immediately, no 0x342 write, IDLE after release.
REQ-041 SHALL cover: macro on, ecall with mstatus=0x8 -> W_STATUS writes 0x300=0x1880, redirect on cycle 4.
REQ-042 SHALL cover: illegal kind -> mcause write of 2; ebreak -> mcause write of 3.
